// File: rtl/mem_nibble_fifo.sv
// Memory-side endpoint of the DMA nibble link: packs inbound nibble pairs
// into bytes, stores them in a circular buffer, and replays them as nibbles.
module mem_nibble_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_nibble,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [3:0]    out_nibble,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [3:0]    stg;
  logic          wr_hi;
  logic          rd_hi;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count_nxt;
  logic [7:0]    rd_byte;
  logic          in_fire;
  logic          out_fire;
  logic          push;
  logic          pop;

  // Handshake outputs come straight from the full/empty flops.
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign push      = in_fire & wr_hi;
  assign pop       = out_fire & rd_hi;

  // Outbound nibble selected by read phase; zero while nothing is stored.
  assign rd_byte    = mem[rd_ptr];
  assign out_nibble = empty ? 4'h0 : (rd_hi ? rd_byte[7:4] : rd_byte[3:0]);

  // Byte occupancy after this edge's push/pop.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage array; deliberately not reset, and never written during flush.
  always_ff @(posedge clk) begin
    if (resetn && !clear && push) begin
      mem[wr_ptr] <= {in_nibble, stg};
    end
  end

  // Pointers, phase bits, staging nibble and occupancy flags.
  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      stg    <= 4'h0;
      wr_hi  <= 1'b0;
      rd_hi  <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (in_fire) begin
        wr_hi <= ~wr_hi;
        if (!wr_hi) begin
          stg <= in_nibble;
        end else begin
          wr_ptr <= wr_ptr + AW'(1);
        end
      end
      if (out_fire) begin
        rd_hi <= ~rd_hi;
        if (rd_hi) begin
          rd_ptr <= rd_ptr + AW'(1);
        end
      end
      count <= count_nxt;
      full  <= (count_nxt == DEPTH_CNT);
      empty <= (count_nxt == '0);
    end
  end

endmodule

// File: tb/tb_mem_nibble_fifo.sv
// Directed and randomized checks of mem_nibble_fifo with a 4-byte buffer.
module tb_mem_nibble_fifo;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic          clear;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_nibble;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_nibble;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  int total = 0;
  int bad   = 0;

  mem_nibble_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_nibble  (in_nibble),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_nibble (out_nibble),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_nibble = 4'h0;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_nibble !== 4'h0) begin bad++; $display("FAIL reset_out_nibble got=%h want=0", out_nibble); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (full !== 1'b0 || empty !== 1'b1) begin bad++; $display("FAIL reset_flags got full=%b empty=%b want 0/1", full, empty); end
    resetn = 1'b1;
    step();
  endtask

  task automatic test_simple_byte();
    in_valid = 1'b1; in_nibble = 4'h5;
    step();
    in_nibble = 4'hA;
    step();
    in_valid = 1'b0;
    total++; if (count !== 3'd1) begin bad++; $display("FAIL simple_count got=%0d want=1", count); end
    total++; if (out_valid !== 1'b1 || out_nibble !== 4'h5) begin bad++; $display("FAIL simple_lo got v=%b n=%h want v=1 n=5", out_valid, out_nibble); end
    out_ready = 1'b1;
    step();
    total++; if (out_valid !== 1'b1 || out_nibble !== 4'hA) begin bad++; $display("FAIL simple_hi got v=%b n=%h want v=1 n=a", out_valid, out_nibble); end
    step();
    out_ready = 1'b0;
    total++; if (empty !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin bad++; $display("FAIL simple_drain got e=%b v=%b c=%0d want 1/0/0", empty, out_valid, count); end
  endtask

  task automatic test_fill_full();
    logic [3:0] drain [8];
    drain = '{4'h2, 4'h2, 4'h3, 4'h3, 4'h4, 4'h4, 4'hF, 4'hE};
    for (int b = 1; b <= 4; b++) begin
      in_valid = 1'b1; in_nibble = 4'(b);
      step();
      step();
    end
    total++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin bad++; $display("FAIL full_set got f=%b r=%b c=%0d want 1/0/4", full, in_ready, count); end
    in_nibble = 4'hF;
    step();
    total++; if (count !== 3'd4 || in_ready !== 1'b0) begin bad++; $display("FAIL full_hold got c=%0d r=%b want 4/0", count, in_ready); end
    out_ready = 1'b1;
    total++; if (out_nibble !== 4'h1) begin bad++; $display("FAIL full_pop_lo got=%h want=1", out_nibble); end
    step();
    total++; if (out_nibble !== 4'h1 || in_ready !== 1'b0) begin bad++; $display("FAIL full_pop_hi got n=%h r=%b want 1/0", out_nibble, in_ready); end
    step();
    out_ready = 1'b0;
    total++; if (in_ready !== 1'b1 || count !== 3'd3) begin bad++; $display("FAIL full_recover got r=%b c=%0d want 1/3", in_ready, count); end
    step();
    in_nibble = 4'hE;
    step();
    in_valid = 1'b0;
    total++; if (count !== 3'd4 || full !== 1'b1) begin bad++; $display("FAIL full_refill got c=%0d f=%b want 4/1", count, full); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if (out_valid !== 1'b1 || out_nibble !== drain[i]) begin bad++; $display("FAIL full_drain[%0d] got v=%b n=%h want v=1 n=%h", i, out_valid, out_nibble, drain[i]); end
      step();
    end
    out_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_empty got=%b want=1", empty); end
  endtask

  task automatic test_wrap();
    int iidx = 0;
    int oidx = 0;
    logic [3:0] exp_n;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && oidx < 20; cyc++) begin
      in_valid  = (iidx < 20);
      in_nibble = (iidx % 2 == 0) ? 4'(iidx / 2) : 4'h0;
      exp_n     = (oidx % 2 == 0) ? 4'(oidx / 2) : 4'h0;
      if (count > 3'd4) begin total++; bad++; $display("FAIL wrap_count got=%0d want<=4", count); end
      if (out_valid) begin
        total++; if (out_nibble !== exp_n) begin bad++; $display("FAIL wrap_data[%0d] got=%h want=%h", oidx, out_nibble, exp_n); end
        oidx++;
      end
      if (in_valid && in_ready) iidx++;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (oidx !== 20) begin bad++; $display("FAIL wrap_total got=%0d want=20", oidx); end
  endtask

  task automatic test_back_to_back();
    in_valid = 1'b1; in_nibble = 4'h1;
    step();
    in_nibble = 4'h2;
    step();
    total++; if (count !== 3'd1) begin bad++; $display("FAIL b2b_pre got=%0d want=1", count); end
    in_nibble = 4'h3; out_ready = 1'b1;
    total++; if (out_nibble !== 4'h1) begin bad++; $display("FAIL b2b_n0 got=%h want=1", out_nibble); end
    step();
    in_nibble = 4'h4;
    total++; if (out_nibble !== 4'h2) begin bad++; $display("FAIL b2b_n1 got=%h want=2", out_nibble); end
    step();
    in_valid = 1'b0;
    total++; if (count !== 3'd1) begin bad++; $display("FAIL b2b_count got=%0d want=1", count); end
    total++; if (out_nibble !== 4'h3) begin bad++; $display("FAIL b2b_n2 got=%h want=3", out_nibble); end
    step();
    total++; if (out_nibble !== 4'h4) begin bad++; $display("FAIL b2b_n3 got=%h want=4", out_nibble); end
    step();
    out_ready = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL b2b_empty got=%b want=1", empty); end
  endtask

  task automatic test_random();
    logic [7:0] q [$];
    logic       m_wr_hi = 1'b0;
    logic       m_rd_hi = 1'b0;
    logic [3:0] m_stg = 4'h0;
    logic [3:0] exp_n;
    logic       acc_in;
    logic       acc_out;
    int         errs = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_nibble = 4'($urandom_range(0, 15));
      #1;
      total++;
      if (in_ready !== (q.size() < DEPTH) || out_valid !== (q.size() != 0) || count !== 3'(q.size())
          || in_ready !== !full || out_valid !== !empty) begin
        bad++; errs++;
        if (errs < 20) $display("FAIL rand_flags cyc=%0d got r=%b v=%b c=%0d want c=%0d", cyc, in_ready, out_valid, count, q.size());
      end
      acc_in  = in_valid && (q.size() < DEPTH);
      acc_out = out_ready && (q.size() != 0);
      if (acc_out) begin
        exp_n = m_rd_hi ? q[0][7:4] : q[0][3:0];
        total++;
        if (out_nibble !== exp_n) begin
          bad++; errs++;
          if (errs < 20) $display("FAIL rand_data cyc=%0d got=%h want=%h", cyc, out_nibble, exp_n);
        end
        if (m_rd_hi) void'(q.pop_front());
        m_rd_hi = ~m_rd_hi;
      end
      if (acc_in) begin
        if (m_wr_hi) q.push_back({in_nibble, m_stg});
        else m_stg = in_nibble;
        m_wr_hi = ~m_wr_hi;
      end
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_clear_reset();
    in_valid = 1'b1; in_nibble = 4'h3;
    step();
    clear = 1'b1; in_nibble = 4'hC;
    step();
    clear = 1'b0;
    total++; if (count !== 3'd0 || empty !== 1'b1) begin bad++; $display("FAIL clr_flush got c=%0d e=%b want 0/1", count, empty); end
    in_nibble = 4'h7;
    step();
    in_nibble = 4'h8;
    step();
    in_valid = 1'b0;
    total++; if (count !== 3'd1 || out_nibble !== 4'h7) begin bad++; $display("FAIL clr_byte_lo got c=%0d n=%h want 1/7", count, out_nibble); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    total++; if (out_nibble !== 4'h8) begin bad++; $display("FAIL clr_byte_hi got=%h want=8", out_nibble); end
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    total++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid got v=%b c=%0d r=%b want 0/0/1", out_valid, count, in_ready); end
    in_valid = 1'b1; in_nibble = 4'h9;
    step();
    in_nibble = 4'hA;
    step();
    in_valid = 1'b0;
    total++; if (count !== 3'd1 || out_nibble !== 4'h9) begin bad++; $display("FAIL rst_realign got c=%0d n=%h want 1/9", count, out_nibble); end
  endtask

  initial begin
    test_reset();
    test_simple_byte();
    test_fill_full();
    test_wrap();
    test_back_to_back();
    test_random();
    test_clear_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_nibble_fifo.md
# mem_nibble_fifo

Memory-side endpoint of the DMA nibble link: sinks the 4-bit DMA-to-memory stream, packs nibble pairs into bytes, and stores them in a DEPTH-byte circular buffer. It sources the stored bytes back to the DMA as a 4-bit memory-to-DMA stream. It replaces the random memory model with a deterministic, checkable store, so DMA transfers in both directions can be verified byte-exactly.

## Interface
- DEPTH, 16, buffer depth in bytes; power of two, at least 2
- AW, 4, pointer width; must equal log2(DEPTH)
- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  reset, synchronous, active-low
- clear  in  1  synchronous flush of pointers, count and phase bits; RAM contents kept
- in_valid  in  1  DMA-to-memory nibble valid
- in_ready  out  1  block can accept an inbound nibble
- in_nibble  in  4  inbound nibble; low nibble of each byte arrives first
- out_valid  out  1  outbound nibble valid
- out_ready  in  1  DMA can accept an outbound nibble
- out_nibble  out  4  outbound nibble; low nibble of each byte is sent first
- count  out  AW+1  number of complete bytes stored (0..DEPTH)
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Transfer rule on each link: a beat is accepted on a rising edge where valid and ready are both high. Valid never depends on ready, and ready never depends on valid.
- Write side state: staging register stg[3:0], phase bit wr_hi, pointer wr_ptr[AW-1:0].
  - Accepted beat with wr_hi=0: stg <= in_nibble; wr_hi <= 1.
  - Accepted beat with wr_hi=1: mem[wr_ptr] <= {in_nibble, stg}; wr_ptr++ (wraps DEPTH-1 -> 0); wr_hi <= 0; the byte is pushed.
- in_ready = !full, in both phases. A half-assembled byte is held in stg indefinitely.
- Read side state: phase bit rd_hi, pointer rd_ptr[AW-1:0].
  - out_valid = !empty.
  - out_nibble = rd_hi ? mem[rd_ptr][7:4] : mem[rd_ptr][3:0]. It is forced to 4'h0 when empty.
  - Accepted beat with rd_hi=0: rd_hi <= 1.
  - Accepted beat with rd_hi=1: rd_ptr++ (wraps); rd_hi <= 0; the byte is popped.
- count update per edge:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop, or on neither.
- Push when full cannot occur, because in_ready is low. Pop when empty cannot occur, because out_valid is low.
- Simultaneous push and pop when count==DEPTH-1 or count==1 is legal; count stays unchanged.
- clear: wr_ptr, rd_ptr, count, wr_hi and rd_hi go to 0; stg goes to 0. Any beats presented in the same cycle are discarded. resetn has priority over clear.
- Reset mid-byte: a partially written byte (wr_hi=1) and a partially read byte (rd_hi=1) are both discarded.

## Timing
- Reset values, visible after the first edge with resetn=0:
  - in_ready=1, out_valid=0, out_nibble=0, count=0, full=0, empty=1.
  - Internal: wr_hi=0, rd_hi=0, both pointers 0.
- RAM is not reset.
- in_ready, out_valid, out_nibble, count, full and empty are decoded from registers only. There is no combinational path from any input to any output.
- Write-to-read latency: the push edge of a byte's high nibble, then out_valid=1 on the next cycle, which is the first cycle that byte's low nibble can be read. This applies when the buffer was empty.
- Full recovery: in_ready returns to 1 in the cycle after the pop edge that drops count below DEPTH.
- Sustained throughput: one nibble per cycle on each side simultaneously, i.e. one byte per 2 cycles.
- The phase bits are not exposed. Byte alignment is guaranteed only from reset or clear.

## Test plan
- Reset then simple byte (DEPTH=4):
  - Stimulus: after reset, send nibbles 0x5 then 0xA with in_valid=1 and out_ready=0.
  - Required: count=1 on the edge after 0xA; out_valid=1 the next cycle with out_nibble=0x5; after one out_ready beat, out_nibble=0xA; after the second beat, empty=1 and out_valid=0.
- Fill to full (DEPTH=4):
  - Stimulus: push bytes 0x11, 0x22, 0x33, 0x44 with out_ready=0.
  - Required: full=1 and in_ready=0 after the 8th nibble; a 9th nibble 0xF is held off.
  - Then pop one byte (0x1, 0x1): in_ready=1 on the next cycle; 0xF is accepted as the low nibble of the next byte.
- Wrap-around:
  - Stimulus: push and pop 10 bytes 0x00..0x09 through DEPTH=4.
  - Required: the output nibble sequence is 0,0,1,0,2,0,…,9,0 in order; count never exceeds 4.
- Simultaneous push and pop:
  - Stimulus: with count=1, present in_valid and out_ready every cycle so a push edge and a pop edge coincide.
  - Required: count stays 1 at that edge; data order is preserved.
- Random handshake stress:
  - Stimulus: in_valid and out_ready each random 50% per cycle for 2000 cycles.
  - Required: a scoreboard of assembled bytes matches exactly; in_ready==!full and out_valid==!empty every cycle.
- Mid-byte clear and reset:
  - Stimulus: push 0x3 (half byte), then assert clear for one cycle, then push 0x7, 0x8.
  - Required: the stored byte is 0x87 and count=1.
  - Repeat with resetn=0 mid-read (rd_hi=1). Required: out_valid=0 and count=0 after reset.
